// File: rtl/regfile_wb_queue_pkg.sv
// rtl/regfile_wb_queue_pkg.sv - shared register-file types for the writeback queue
package regfile_wb_queue_pkg;

    localparam int CREG_NUM    = 32;
    localparam int WORD_W      = 32;
    localparam int CREG_ADDR_W = $clog2(CREG_NUM);

    typedef logic [WORD_W-1:0]      word_t;
    typedef logic [CREG_ADDR_W-1:0] creg_addr_t;

    typedef struct packed {
        creg_addr_t addr;
        word_t      data;
    } wbq_entry_t;

    // Register 0 is hardwired to zero, so writes to it are dropped and it never bypasses.
    function automatic logic is_zero_reg(input creg_addr_t a);
        return (a == '0);
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - producer, regfile write-port and bypass signals of the queue
interface regfile_wb_queue_if
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             in_valid;
    logic             in_ready;
    creg_addr_t       in_addr;
    word_t            in_data;
    logic             port_busy;
    logic             wb_we;
    creg_addr_t       wb_addr;
    word_t            wb_data;
    creg_addr_t       ra1;
    creg_addr_t       ra2;
    logic             byp1_hit;
    logic             byp2_hit;
    word_t            byp1_data;
    word_t            byp2_data;
    logic [PTR_W:0]   count;
    logic             empty;

    modport master (
        output in_valid, in_addr, in_data, port_busy, ra1, ra2,
        input  in_ready, wb_we, wb_addr, wb_data,
        input  byp1_hit, byp2_hit, byp1_data, byp2_data, count, empty
    );

    modport slave (
        input  in_valid, in_addr, in_data, port_busy, ra1, ra2,
        output in_ready, wb_we, wb_addr, wb_data,
        output byp1_hit, byp2_hit, byp1_data, byp2_data, count, empty
    );

endinterface

// File: rtl/regfile_wb_queue_bypass_match.sv
// rtl/regfile_wb_queue_bypass_match.sv - youngest pending write matching one read address
module wbq_bypass_match
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wbq_entry_t       i_entries [DEPTH],
    input  logic [DEPTH-1:0] i_valid,
    input  logic [PTR_W-1:0] i_head,
    input  creg_addr_t       i_ra,
    output logic             o_hit,
    output word_t            o_data
);

    logic [PTR_W-1:0] w_idx;

    // Walk from oldest to youngest so a later (younger) match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].addr == i_ra) && !is_zero_reg(i_ra)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - buffers long-latency register writes and drains them into free regfile write-port cycles
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               resetn,
    regfile_wb_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    wbq_entry_t       r_entry [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_alloc;
    logic             w_pop;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on occupancy, never on a same-cycle pop.
    assign w_push  = bus.in_valid & ~w_full;
    assign w_alloc = w_push & ~is_zero_reg(bus.in_addr);
    assign w_pop   = ~w_empty & ~bus.port_busy;

    assign bus.in_ready = ~w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;
    assign bus.wb_we    = w_pop;
    assign bus.wb_addr  = r_entry[r_head].addr;
    assign bus.wb_data  = r_entry[r_head].data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            // Pop and alloc never target the same slot: pop needs count>0, alloc needs count<DEPTH.
            if (w_alloc) begin
                r_entry[r_tail].addr <= bus.in_addr;
                r_entry[r_tail].data <= bus.in_data;
                r_valid[r_tail]      <= 1'b1;
                r_tail               <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    wbq_bypass_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_byp1 (
        .i_entries (r_entry),
        .i_valid   (r_valid),
        .i_head    (r_head),
        .i_ra      (bus.ra1),
        .o_hit     (bus.byp1_hit),
        .o_data    (bus.byp1_data)
    );

    wbq_bypass_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_byp2 (
        .i_entries (r_entry),
        .i_valid   (r_valid),
        .i_head    (r_head),
        .i_ra      (bus.ra2),
        .o_hit     (bus.byp2_hit),
        .o_data    (bus.byp2_data)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - directed-vector bench for the regfile writeback queue
module tb_regfile_wb_queue;
    import regfile_wb_queue_pkg::*;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;

    regfile_wb_queue_if #(.DEPTH(4)) bus ();

    regfile_wb_queue #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Running invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            vectors++;
            if (bus.count > 3'd4) begin
                miscompares++;
                $display("FAIL inv_count got %0d want <=4", bus.count);
            end
            vectors++;
            if (bus.wb_we && bus.port_busy) begin
                miscompares++;
                $display("FAIL inv_we_busy got we=1 busy=1 want we=0");
            end
        end
    end

    task automatic test_reset();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", bus.in_ready); end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty got %b want 1", bus.empty); end
        vectors++; if (bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b want 0", bus.wb_we); end
        vectors++; if (bus.count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", bus.count); end
        vectors++; if (bus.byp1_hit !== 1'b0 || bus.byp2_hit !== 1'b0) begin miscompares++; $display("FAIL rst_hit got %b%b want 00", bus.byp1_hit, bus.byp2_hit); end
    endtask

    task automatic test_single_push();
        bus.port_busy = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 5'd5;
        bus.in_data   = 32'h1234_5678;
        step();
        bus.in_valid = 1'b0;
        vectors++; if (bus.wb_we !== 1'b1) begin miscompares++; $display("FAIL single_we got %b want 1", bus.wb_we); end
        vectors++; if (bus.wb_addr !== 5'd5) begin miscompares++; $display("FAIL single_addr got %0d want 5", bus.wb_addr); end
        vectors++; if (bus.wb_data !== 32'h1234_5678) begin miscompares++; $display("FAIL single_data got %h want 12345678", bus.wb_data); end
        step();
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL single_empty got %b want 1", bus.empty); end
        vectors++; if (bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL single_we_after got %b want 0", bus.wb_we); end
    endtask

    task automatic test_fill_drain();
        bus.port_busy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'(i);
            bus.in_data  = 32'hA0 + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b want 0", bus.in_ready); end
        vectors++; if (bus.count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d want 4", bus.count); end
        vectors++; if (bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL fill_stall got %b want 0", bus.wb_we); end
        bus.port_busy = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'(i) || bus.wb_data !== 32'hA0 + 32'(i))
                begin miscompares++; $display("FAIL drain_%0d got we=%b a=%0d d=%h want we=1 a=%0d d=%h", i, bus.wb_we, bus.wb_addr, bus.wb_data, i, 32'hA0 + 32'(i)); end
            step();
        end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_full_pop_push();
        bus.port_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'd8 + 5'(i);
            bus.in_data  = 32'hB0 + 32'(i);
            step();
        end
        bus.in_addr   = 5'd12;
        bus.in_data   = 32'hC0;
        bus.port_busy = 1'b0;
        #1;
        vectors++; if (bus.in_ready !== 1'b0 || bus.wb_we !== 1'b1) begin miscompares++; $display("FAIL full_pop got ready=%b we=%b want ready=0 we=1", bus.in_ready, bus.wb_we); end
        step();
        vectors++; if (bus.count !== 3'd3 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL after_full_pop got count=%0d ready=%b want count=3 ready=1", bus.count, bus.in_ready); end
        vectors++; if (bus.wb_addr !== 5'd9) begin miscompares++; $display("FAIL after_full_head got %0d want 9", bus.wb_addr); end
        step();
        bus.in_valid = 1'b0;
        vectors++; if (bus.count !== 3'd3) begin miscompares++; $display("FAIL push_pop_count got %0d want 3", bus.count); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd10 + 5'(i))
                begin miscompares++; $display("FAIL full_drain_%0d got we=%b a=%0d want we=1 a=%0d", i, bus.wb_we, bus.wb_addr, 10 + i); end
            step();
        end
        vectors++; if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL full_drain_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_bypass();
        bus.port_busy = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 5'd7;
        bus.in_data   = 32'h11;
        step();
        bus.in_data   = 32'h22;
        step();
        bus.in_valid  = 1'b0;
        bus.ra1       = 5'd7;
        bus.ra2       = 5'd0;
        #1;
        vectors++; if (bus.byp1_hit !== 1'b1 || bus.byp1_data !== 32'h22) begin miscompares++; $display("FAIL byp_young got hit=%b d=%h want hit=1 d=22", bus.byp1_hit, bus.byp1_data); end
        vectors++; if (bus.byp2_hit !== 1'b0) begin miscompares++; $display("FAIL byp_r0 got %b want 0", bus.byp2_hit); end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h33;
        step();
        bus.in_valid  = 1'b0;
        bus.ra2       = 5'd7;
        #1;
        vectors++; if (bus.byp1_data !== 32'h33) begin miscompares++; $display("FAIL byp_wrap got %h want 33", bus.byp1_data); end
        bus.port_busy = 1'b0;
        #1;
        vectors++; if (bus.wb_data !== 32'h11 || bus.byp1_data !== 32'h33) begin miscompares++; $display("FAIL byp_pop1 got wb=%h byp=%h want wb=11 byp=33", bus.wb_data, bus.byp1_data); end
        step();
        step();
        vectors++; if (bus.wb_we !== 1'b1 || bus.byp2_hit !== 1'b1 || bus.byp2_data !== 32'h33) begin miscompares++; $display("FAIL byp_headpop got we=%b hit=%b d=%h want we=1 hit=1 d=33", bus.wb_we, bus.byp2_hit, bus.byp2_data); end
        step();
        vectors++; if (bus.byp1_hit !== 1'b0 || bus.empty !== 1'b1) begin miscompares++; $display("FAIL byp_drained got hit=%b empty=%b want hit=0 empty=1", bus.byp1_hit, bus.empty); end
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd0;
    endtask

    task automatic test_zero_addr();
        bus.port_busy = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_addr   = 5'd0;
        bus.in_data   = 32'hDEAD;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready got %b want 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        vectors++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL zero_alloc got count=%0d we=%b want count=0 we=0", bus.count, bus.wb_we); end
        step();
        vectors++; if (bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL zero_later_we got %b want 0", bus.wb_we); end
    endtask

    task automatic test_async_reset();
        bus.port_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_addr  = 5'(i);
            bus.in_data  = 32'hE0 + 32'(i);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.port_busy = 1'b0;
        bus.ra1       = 5'd1;
        #2;
        vectors++; if (bus.count !== 3'd3 || bus.wb_we !== 1'b1) begin miscompares++; $display("FAIL pre_reset got count=%0d we=%b want count=3 we=1", bus.count, bus.wb_we); end
        step();
        #2;
        resetn = 1'b0;
        #1;
        vectors++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL async_rst got count=%0d empty=%b ready=%b want 0 1 1", bus.count, bus.empty, bus.in_ready); end
        vectors++; if (bus.wb_we !== 1'b0 || bus.byp1_hit !== 1'b0) begin miscompares++; $display("FAIL async_rst_out got we=%b hit=%b want 0 0", bus.wb_we, bus.byp1_hit); end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step();
        vectors++; if (bus.count !== 3'd0 || bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL post_rst got count=%0d we=%b want 0 0", bus.count, bus.wb_we); end
        step();
        vectors++; if (bus.wb_we !== 1'b0) begin miscompares++; $display("FAIL post_rst_stale got %b want 0", bus.wb_we); end
        bus.ra1 = 5'd0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_data   = '0;
        bus.port_busy = 1'b0;
        bus.ra1       = '0;
        bus.ra2       = '0;
        #12;
        test_reset();
        resetn = 1'b1;
        step();
        test_single_push();
        test_fill_drain();
        test_full_pop_push();
        test_bypass();
        test_zero_addr();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
